// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative signed/unsigned multiply/divide engine, one bit per cycle
// Optional multiply-accumulate (MADD/MSUB) enabled by defining MULDIV_ACC_EN.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 is_div_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 acc_i,
    input  logic                 sub_i,
    input  logic [WIDTH-1:0]     hi_i,
    input  logic [WIDTH-1:0]     lo_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 div_zero_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CW-1:0]          counter;
    logic [2*WIDTH-1:0]     work;
    logic [WIDTH-1:0]       opnd;
    logic                   is_div_q;
    logic                   neg_res_q;
    logic                   neg_rem_q;
    logic [2*WIDTH-1:0]     result_q;
    logic                   div_zero_q;

    logic                   accept;
    logic                   div_by_zero;
    logic [WIDTH-1:0]       abs1;
    logic [WIDTH-1:0]       abs2;
    logic [WIDTH:0]         mult_sum;
    logic [2*WIDTH:0]       div_sh;
    logic [WIDTH:0]         div_trial;
    logic [2*WIDTH-1:0]     work_nxt;
    logic [2*WIDTH-1:0]     prod;
    logic [WIDTH-1:0]       quot;
    logic [WIDTH-1:0]       rem;
    logic [2*WIDTH-1:0]     fixed;

    assign accept      = (state == IDLE) && start_i && !annul_i;
    assign div_by_zero = is_div_i && (opdata2_i == '0);
    assign abs1        = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign abs2        = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // Multiply: {hi,lo} with multiplier in lo, add multiplicand to hi on lo[0], shift right.
    // Divide: {rem,dividend} shifted left, trial-subtract divisor from the widened remainder.
    assign mult_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
    assign div_sh    = {work, 1'b0};
    assign div_trial = div_sh[2*WIDTH:WIDTH] - {1'b0, opnd};
    assign work_nxt  = is_div_q
                     ? (div_trial[WIDTH] ? div_sh[2*WIDTH-1:0]
                                         : {div_trial[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1})
                     : {mult_sum, work[WIDTH-1:1]};

    assign prod = neg_res_q ? -work : work;
    assign quot = neg_res_q ? -work[WIDTH-1:0] : work[WIDTH-1:0];
    assign rem  = neg_rem_q ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];

`ifdef MULDIV_ACC_EN
    logic                   acc_q;
    logic                   sub_q;
    logic [2*WIDTH-1:0]     hilo_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= 1'b0;
            sub_q  <= 1'b0;
            hilo_q <= '0;
        end else if (accept) begin
            acc_q  <= acc_i && !is_div_i;
            sub_q  <= sub_i;
            hilo_q <= {hi_i, lo_i};
        end
    end

    always_comb begin
        fixed = prod;
        if (is_div_q)
            fixed = {rem, quot};
        else if (acc_q)
            fixed = sub_q ? (hilo_q - prod) : (hilo_q + prod);
    end
`else
    wire unused_acc = ^{acc_i, sub_i, hi_i, lo_i};

    assign fixed = is_div_q ? {rem, quot} : prod;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = div_by_zero ? DONE : CALC;
            CALC: if (annul_i) state_nxt = IDLE;
                  else if (counter == LAST) state_nxt = FIX;
            FIX:  state_nxt = annul_i ? IDLE : DONE;
            DONE: if (annul_i || !start_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter    <= '0;
            work       <= '0;
            opnd       <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (div_by_zero) begin
                        result_q   <= '0;
                        div_zero_q <= 1'b1;
                    end else begin
                        div_zero_q <= 1'b0;
                        counter    <= '0;
                        is_div_q   <= is_div_i;
                        neg_res_q  <= signed_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem_q  <= signed_i && opdata1_i[WIDTH-1];
                        work       <= is_div_i ? {{WIDTH{1'b0}}, abs1} : {{WIDTH{1'b0}}, abs2};
                        opnd       <= is_div_i ? abs2 : abs1;
                    end
                end
                CALC: begin
                    if (annul_i) begin
                        result_q <= '0;
                    end else begin
                        work    <= work_nxt;
                        counter <= counter + 1'b1;
                    end
                end
                FIX:  result_q <= annul_i ? '0 : fixed;
                DONE: if (annul_i) result_q <= '0;
                default: ;
            endcase
        end
    end

    assign result_o   = result_q;
    assign ready_o    = (state == DONE);
    assign busy_o     = (state != IDLE);
    assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit (WIDTH=32)
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, annul_i, is_div_i, signed_i, acc_i, sub_i;
    logic [31:0] opdata1_i, opdata2_i, hi_i, lo_i;
    logic [63:0] result_o;
    logic        ready_o, busy_o, div_zero_o;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
        .is_div_i(is_div_i), .signed_i(signed_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .acc_i(acc_i), .sub_i(sub_i), .hi_i(hi_i), .lo_i(lo_i),
        .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o), .div_zero_o(div_zero_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic d, input logic s,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic ac, input logic sb,
                                          input logic [31:0] h, input logic [31:0] l);
        logic [63:0] r, qv, rv;
        longint      sa, sbv;
        if (d) begin
            if (b == 32'h0) return 64'h0;
            if (s) begin
                sa  = longint'($signed(a));
                sbv = longint'($signed(b));
                qv  = sa / sbv;
                rv  = sa % sbv;
            end else begin
                qv = {32'h0, a} / {32'h0, b};
                rv = {32'h0, a} % {32'h0, b};
            end
            return {rv[31:0], qv[31:0]};
        end
        if (s) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            r   = sa * sbv;
        end else begin
            r = {32'h0, a} * {32'h0, b};
        end
`ifdef MULDIV_ACC_EN
        if (ac) r = sb ? ({h, l} - r) : ({h, l} + r);
`else
        if (ac && sb && (h == l)) r = r;
`endif
        return r;
    endfunction

    task automatic drive_op(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b,
                            input logic ac, input logic sb, input logic [31:0] h, input logic [31:0] l);
        is_div_i = d; signed_i = s; opdata1_i = a; opdata2_i = b;
        acc_i = ac; sub_i = sb; hi_i = h; lo_i = l;
        start_i = 1'b1;
    endtask

    // Issues one operation from a negedge (cycle 0), reports the first cycle ready_o is seen.
    task automatic run_op(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic ac, input logic sb, input logic [31:0] h, input logic [31:0] l,
                          output logic [63:0] res, output int cyc, output logic dz);
        @(negedge clk);
        drive_op(d, s, a, b, ac, sb, h, l);
        cyc = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (ready_o) begin
                cyc = k;
                break;
            end
        end
        res = result_o;
        dz  = div_zero_o;
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; start_i = 1'b0; annul_i = 1'b0;
        drive_op(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (result_o !== 64'h0) begin n_errors++; $display("FAIL reset_result got %h want 0", result_o); end
        n_checks++; if (ready_o !== 1'b0) begin n_errors++; $display("FAIL reset_ready got %b want 0", ready_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
        n_checks++; if (div_zero_o !== 1'b0) begin n_errors++; $display("FAIL reset_dz got %b want 0", div_zero_o); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed;
        logic [63:0] res;
        int          cyc;
        logic        dz;
        run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0, 32'h0, 32'h0, res, cyc, dz);
        n_checks++; if (res !== 64'h0000_0001_FFFF_FFFE) begin n_errors++; $display("FAIL umul_result got %h want 00000001fffffffe", res); end
        n_checks++; if (cyc !== 34) begin n_errors++; $display("FAIL umul_latency got %0d want 34", cyc); end

        run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h2, 1'b0, 1'b0, 32'h0, 32'h0, res, cyc, dz);
        n_checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_errors++; $display("FAIL sdiv_m7_2 got %h want fffffffffffffffd", res); end
        n_checks++; if (dz !== 1'b0) begin n_errors++; $display("FAIL sdiv_m7_2_dz got %b want 0", dz); end

        run_op(1'b1, 1'b0, 32'h5, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, res, cyc, dz);
        n_checks++; if (cyc !== 1) begin n_errors++; $display("FAIL div0_latency got %0d want 1", cyc); end
        n_checks++; if (res !== 64'h0) begin n_errors++; $display("FAIL div0_result got %h want 0", res); end
        n_checks++; if (dz !== 1'b1) begin n_errors++; $display("FAIL div0_dz got %b want 1", dz); end

        run_op(1'b0, 1'b0, 32'h3, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, res, cyc, dz);
        n_checks++; if (dz !== 1'b0) begin n_errors++; $display("FAIL dz_clear got %b want 0", dz); end
        n_checks++; if (res !== 64'hC) begin n_errors++; $display("FAIL umul_3_4 got %h want c", res); end

        run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 32'h0, res, cyc, dz);
        n_checks++; if (res !== 64'h0000_0000_8000_0000) begin n_errors++; $display("FAIL sdiv_minneg got %h want 0000000080000000", res); end

        run_op(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 32'h0, res, cyc, dz);
        n_checks++; if (res !== 64'h4000_0000_0000_0000) begin n_errors++; $display("FAIL smul_minneg got %h want 4000000000000000", res); end
    endtask

    task automatic test_accumulate;
        logic [63:0] res, exp0, exp1;
        int          cyc;
        logic        dz;
`ifdef MULDIV_ACC_EN
        exp0 = 64'hA;
        exp1 = 64'h16;
`else
        exp0 = 64'hFFFF_FFFF_FFFF_FFFA;
        exp1 = 64'hFFFF_FFFF_FFFF_FFFA;
`endif
        run_op(1'b0, 1'b1, 32'h3, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0, 32'h10, res, cyc, dz);
        n_checks++; if (res !== exp0) begin n_errors++; $display("FAIL madd got %h want %h", res, exp0); end
        run_op(1'b0, 1'b1, 32'h3, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'h0, 32'h10, res, cyc, dz);
        n_checks++; if (res !== exp1) begin n_errors++; $display("FAIL msub got %h want %h", res, exp1); end
        run_op(1'b1, 1'b0, 32'h64, 32'h7, 1'b1, 1'b0, 32'h1, 32'h1, res, cyc, dz);
        n_checks++; if (res !== 64'h0000_0002_0000_000E) begin n_errors++; $display("FAIL div_ignores_acc got %h want 000000020000000e", res); end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random;
        logic [63:0] res, exp;
        int          cyc, exp_cyc;
        logic        dz, d, s, ac, sb;
        logic [31:0] a, b, h, l;
        for (int i = 0; i < 60; i++) begin
            d  = 1'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 1));
            ac = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            a  = pick_operand();
            b  = pick_operand();
            h  = $urandom;
            l  = $urandom;
            exp     = model(d, s, a, b, ac, sb, h, l);
            exp_cyc = (d && b == 32'h0) ? 1 : 34;
            run_op(d, s, a, b, ac, sb, h, l, res, cyc, dz);
            n_checks++; if (res !== exp) begin n_errors++; $display("FAIL rand_result[%0d] div=%b sgn=%b a=%h b=%h got %h want %h", i, d, s, a, b, res, exp); end
            n_checks++; if (cyc !== exp_cyc) begin n_errors++; $display("FAIL rand_latency[%0d] got %0d want %0d", i, cyc, exp_cyc); end
            n_checks++; if (dz !== (d && b == 32'h0)) begin n_errors++; $display("FAIL rand_dz[%0d] got %b want %b", i, dz, d && b == 32'h0); end
        end
    endtask

    task automatic test_annul;
        logic [63:0] res;
        int          cyc;
        logic        dz;
        int          early_ready;
        @(negedge clk);
        drive_op(1'b0, 1'b0, 32'h1234, 32'h5678, 1'b0, 1'b0, 32'h0, 32'h0);
        early_ready = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (ready_o) early_ready++;
        end
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (early_ready !== 0) begin n_errors++; $display("FAIL annul_no_ready got %0d want 0", early_ready); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL annul_busy got %b want 0", busy_o); end
        n_checks++; if (result_o !== 64'h0) begin n_errors++; $display("FAIL annul_result got %h want 0", result_o); end
        @(posedge clk); #1;
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL annul_wins_idle got %b want 0", busy_o); end
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        run_op(1'b0, 1'b0, 32'h1234, 32'h5678, 1'b0, 1'b0, 32'h0, 32'h0, res, cyc, dz);
        n_checks++; if (res !== 64'h0000_0000_0626_0060) begin n_errors++; $display("FAIL after_annul got %h want 0000000006260060", res); end
        n_checks++; if (cyc !== 34) begin n_errors++; $display("FAIL after_annul_latency got %0d want 34", cyc); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] res, held;
        int          cyc;
        logic        dz;
        @(negedge clk);
        drive_op(1'b1, 1'b0, 32'd1000, 32'd7, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (ready_o) begin cyc = k; break; end
        end
        held = result_o;
        n_checks++; if (held !== 64'h0000_0006_0000_008E) begin n_errors++; $display("FAIL hold_result got %h want 000000060000008e", held); end
        drive_op(1'b0, 1'b0, 32'h9, 32'h9, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) begin
            @(posedge clk); #1;
            n_checks++; if (!ready_o || result_o !== held) begin n_errors++; $display("FAIL hold_stable ready=%b got %h want %h", ready_o, result_o, held); end
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (ready_o !== 1'b0 || busy_o !== 1'b0) begin n_errors++; $display("FAIL drop_idle ready=%b busy=%b want 0 0", ready_o, busy_o); end
        run_op(1'b0, 1'b0, 32'h9, 32'h9, 1'b0, 1'b0, 32'h0, 32'h0, res, cyc, dz);
        n_checks++; if (res !== 64'h51) begin n_errors++; $display("FAIL b2b_result got %h want 51", res); end
    endtask

    task automatic test_reset_mid;
        logic [63:0] res;
        int          cyc;
        logic        dz;
        run_op(1'b1, 1'b0, 32'h5, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, res, cyc, dz);
        @(negedge clk);
        drive_op(1'b0, 1'b0, 32'hFFFF, 32'hFFFF, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++; if (busy_o !== 1'b0 || ready_o !== 1'b0) begin n_errors++; $display("FAIL rst_mid_ctl busy=%b ready=%b want 0 0", busy_o, ready_o); end
        n_checks++; if (result_o !== 64'h0 || div_zero_o !== 1'b0) begin n_errors++; $display("FAIL rst_mid_data result=%h dz=%b want 0 0", result_o, div_zero_o); end
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_op(1'b0, 1'b0, 32'hFFFF, 32'hFFFF, 1'b0, 1'b0, 32'h0, 32'h0, res, cyc, dz);
        n_checks++; if (res !== 64'hFFFE_0001) begin n_errors++; $display("FAIL after_rst got %h want fffe0001", res); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_accumulate();
        test_random();
        test_annul();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
